// File: rtl/fc_mac_array.sv
// fc_mac_array: pipelined multi-lane signed MAC for the FC layer datapath.
// Stages: S1 lane products, S2 adder tree, S3 accumulator, then an output
// register holding the rounded, shifted and saturated dot product.
// The whole pipe freezes while a result waits for out_ready.
module fc_mac_array #(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 4,
  parameter int ACC_WIDTH  = 32,
  parameter int FRAC_BITS  = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          in_last,
  input  logic [LANES*DATA_WIDTH-1:0]   a_vec,
  input  logic [LANES*DATA_WIDTH-1:0]   b_vec,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [2*DATA_WIDTH-1:0]       out_data,
  output logic                          out_sat
);

  localparam int PW = 2 * DATA_WIDTH;
  localparam int LW = $clog2(LANES);
  localparam int SW = PW + LW;

  // Half-LSB rounding constant; collapses to zero when FRAC_BITS is 0.
  localparam logic signed [ACC_WIDTH:0] RND =
    ({{ACC_WIDTH{1'b0}}, 1'b1} << FRAC_BITS) >> 1;
  localparam logic signed [ACC_WIDTH:0] SAT_MAX =
    {{(ACC_WIDTH-PW+2){1'b0}}, {(PW-1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] SAT_MIN =
    {{(ACC_WIDTH-PW+2){1'b1}}, {(PW-1){1'b0}}};

  logic signed [PW-1:0]        prod_d [LANES];
  logic signed [PW-1:0]        prod_q [LANES];
  logic                        s1_valid_d, s1_valid_q, s1_last_d, s1_last_q;
  logic signed [SW-1:0]        sum_d, sum_q;
  logic                        s2_valid_d, s2_valid_q, s2_last_d, s2_last_q;
  logic signed [ACC_WIDTH-1:0] acc_d, acc_q;
  logic                        s3_valid_d, s3_valid_q, s3_last_d, s3_last_q;
  logic                        first_d, first_q;
  logic                        out_valid_d, out_valid_q;
  logic [PW-1:0]               out_data_d, out_data_q;
  logic                        out_sat_d, out_sat_q;
  logic signed [ACC_WIDTH:0]   rnd_sum, shifted;
  logic                        advance;

  assign advance   = !(out_valid_q && !out_ready);
  assign in_ready  = advance;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

  // S1: lane products, loaded only on an accepted beat.
  always_comb begin
    prod_d     = prod_q;
    s1_valid_d = s1_valid_q;
    s1_last_d  = s1_last_q;
    if (advance) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_last_d = in_last;
        for (int i = 0; i < LANES; i++) begin
          prod_d[i] = $signed(a_vec[i*DATA_WIDTH +: DATA_WIDTH]) *
                      $signed(b_vec[i*DATA_WIDTH +: DATA_WIDTH]);
        end
      end
    end
  end

  // S2: sign-extended adder tree over the registered products.
  always_comb begin
    sum_d      = sum_q;
    s2_valid_d = s2_valid_q;
    s2_last_d  = s2_last_q;
    if (advance) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_last_d = s1_last_q;
        sum_d     = '0;
        for (int i = 0; i < LANES; i++) begin
          sum_d = sum_d + SW'(prod_q[i]);
        end
      end
    end
  end

  // S3: accumulate; the first beat of each vector overwrites the accumulator.
  always_comb begin
    acc_d      = acc_q;
    first_d    = first_q;
    s3_valid_d = s3_valid_q;
    s3_last_d  = s3_last_q;
    if (advance) begin
      s3_valid_d = s2_valid_q;
      if (s2_valid_q) begin
        s3_last_d = s2_last_q;
        first_d   = s2_last_q;
        acc_d     = first_q ? ACC_WIDTH'(sum_q) : acc_q + ACC_WIDTH'(sum_q);
      end
    end
  end

  // Output: round, arithmetic shift and clamp the finished dot product.
  always_comb begin
    rnd_sum     = {acc_q[ACC_WIDTH-1], acc_q} + RND;
    shifted     = rnd_sum >>> FRAC_BITS;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    if (advance) begin
      out_valid_d = s3_valid_q && s3_last_q;
      if (s3_valid_q && s3_last_q) begin
        if (shifted > SAT_MAX) begin
          out_data_d = SAT_MAX[PW-1:0];
          out_sat_d  = 1'b1;
        end else if (shifted < SAT_MIN) begin
          out_data_d = SAT_MIN[PW-1:0];
          out_sat_d  = 1'b1;
        end else begin
          out_data_d = shifted[PW-1:0];
          out_sat_d  = 1'b0;
        end
      end
    end
  end

  // All pipeline state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      prod_q      <= '{default: '0};
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      sum_q       <= '0;
      s2_valid_q  <= 1'b0;
      s2_last_q   <= 1'b0;
      acc_q       <= '0;
      s3_valid_q  <= 1'b0;
      s3_last_q   <= 1'b0;
      first_q     <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      prod_q      <= prod_d;
      s1_valid_q  <= s1_valid_d;
      s1_last_q   <= s1_last_d;
      sum_q       <= sum_d;
      s2_valid_q  <= s2_valid_d;
      s2_last_q   <= s2_last_d;
      acc_q       <= acc_d;
      s3_valid_q  <= s3_valid_d;
      s3_last_q   <= s3_last_d;
      first_q     <= first_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
    end
  end

endmodule
